// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch op codes and sequencer state type
package cpu_pkg;

   localparam logic [1:0] BR_JCC  = 2'b00;
   localparam logic [1:0] BR_JMP  = 2'b01;
   localparam logic [1:0] BR_CALL = 2'b10;
   localparam logic [1:0] BR_RET  = 2'b11;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - branch request / fetch address bundle for pc_sequencer
interface pc_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              cond_i;
   logic              br_valid;
   logic              br_ready;
   logic [1:0]        br_op;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] br_ret_addr;
   logic              fetch_ready;
   logic [ADDR_W-1:0] pc;
   logic              fetch_valid;
   logic              flush;
   logic              ras_err;

   modport master (
      output cond_i, br_valid, br_op, br_target, br_ret_addr, fetch_ready,
      input  br_ready, pc, fetch_valid, flush, ras_err
   );

   modport slave (
      input  cond_i, br_valid, br_op, br_target, br_ret_addr, fetch_ready,
      output br_ready, pc, fetch_valid, flush, ras_err
   );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - LIFO return-address stack, drops push when full and pop when empty
module ras_stack #(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_data,
   output logic [ADDR_W-1:0] o_top,
   output logic              o_empty,
   output logic              o_full
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
   logic [CNT_W-1:0]  r_cnt;
   logic [PTR_W-1:0]  w_top_idx;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == CNT_W'(RAS_DEPTH));
   assign w_top_idx = PTR_W'(r_cnt - CNT_W'(1));
   assign o_top     = r_mem[w_top_idx];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_do_push) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_do_pop) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Entries need no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_cnt[PTR_W-1:0]] <= i_data;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner: sequential step, branch/call/return redirect with one-cycle flush
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   seq_state_t        r_state;
   seq_state_t        w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic              r_ras_err;

   logic              w_accept;
   logic              w_taken;
   logic [ADDR_W-1:0] w_target;
   logic              w_push;
   logic              w_pop;
   logic              w_ras_bad;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_ras_empty;
   logic              w_ras_full;

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.br_ret_addr),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty),
      .o_full  (w_ras_full)
   );

   assign w_accept = (r_state == RUN) && bus.br_valid;

   always_comb begin
      w_taken   = 1'b0;
      w_target  = bus.br_target;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_ras_bad = 1'b0;
      if (w_accept) begin
         case (bus.br_op)
            BR_JCC:  w_taken = bus.cond_i;
            BR_JMP:  w_taken = 1'b1;
            BR_CALL: begin
               w_taken   = 1'b1;
               w_push    = 1'b1;
               w_ras_bad = w_ras_full;
            end
            default: begin
               w_taken   = !w_ras_empty;
               w_pop     = !w_ras_empty;
               w_ras_bad = w_ras_empty;
               w_target  = w_ras_top;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Handshake outputs depend on r_state only, never on inputs.
   always_comb begin
      w_state_next    = r_state;
      bus.br_ready    = 1'b0;
      bus.fetch_valid = 1'b0;
      bus.flush       = 1'b0;
      case (r_state)
         BOOT:     w_state_next = RUN;
         RUN: begin
            bus.br_ready    = 1'b1;
            bus.fetch_valid = 1'b1;
            if (w_taken) begin
               w_state_next = REDIRECT;
            end
         end
         REDIRECT: begin
            bus.flush    = 1'b1;
            w_state_next = RUN;
         end
         default:  w_state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc <= '0;
      end else if (r_state == RUN) begin
         if (w_taken) begin
            r_pc <= w_target;
         end else if (bus.fetch_ready) begin
            r_pc <= r_pc + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ras_err <= 1'b0;
      end else if (w_ras_bad) begin
         r_ras_err <= 1'b1;
      end
   end

   assign bus.pc      = r_pc;
   assign bus.ras_err = r_ras_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plus random bench for pc_sequencer against a queue-based reference
module tb_pc_sequencer;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   pc_sequencer_if #(.ADDR_W(8)) bus ();

   pc_sequencer #(
      .ADDR_W    (8),
      .RAS_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: boot/bubble flags, PC as an integer, RAS as a queue.
   int         m_pc;
   bit         m_boot;
   bit         m_bub;
   bit         m_err;
   logic [7:0] m_ras[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [7:0] tgt;
      bit         tk;
      if (!rst) begin
         m_pc = 0; m_boot = 1; m_bub = 0; m_err = 0;
         m_ras.delete();
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_bub) begin
         m_bub = 0;
      end else begin
         tk  = 0;
         tgt = bus.br_target;
         if (bus.br_valid) begin
            case (bus.br_op)
               2'd0: tk = bus.cond_i;
               2'd1: tk = 1;
               2'd2: begin
                  tk = 1;
                  if (m_ras.size() == 4) m_err = 1;
                  else m_ras.push_back(bus.br_ret_addr);
               end
               default: begin
                  if (m_ras.size() == 0) m_err = 1;
                  else begin
                     tk  = 1;
                     tgt = m_ras.pop_back();
                  end
               end
            endcase
         end
         if (tk) begin
            m_pc  = tgt;
            m_bub = 1;
         end else if (bus.fetch_ready) begin
            m_pc = (m_pc + 1) % 256;
         end
      end
   endtask

   task automatic step();
      logic [7:0] exp_pc;
      model_edge();
      @(posedge clk);
      #1;
      exp_pc = m_pc[7:0];
      chk("pc", bus.pc, exp_pc);
      chk("fetch_valid", bus.fetch_valid, !m_boot && !m_bub);
      chk("br_ready", bus.br_ready, !m_boot && !m_bub);
      chk("flush", bus.flush, m_bub);
      chk("ras_err", bus.ras_err, m_err);
   endtask

   task automatic set_br(input bit v, input logic [1:0] op, input bit c,
                         input logic [7:0] tgt, input logic [7:0] ret);
      bus.br_valid    = v;
      bus.br_op       = op;
      bus.cond_i      = c;
      bus.br_target   = tgt;
      bus.br_ret_addr = ret;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.fetch_ready = 1'b1;
      set_br(0, 2'd0, 0, 8'h00, 8'h00);

      step();
      step();
      chk("rst_pc", bus.pc, 8'h00);
      chk("rst_fv", bus.fetch_valid, 1'b0);

      rst = 1'b1;
      step();
      chk("boot_pc0", bus.pc, 8'h00);
      chk("boot_fv", bus.fetch_valid, 1'b1);
      for (int i = 0; i < 5; i++) step();
      chk("seq_pc5", bus.pc, 8'h05);

      for (int i = 0; i < 300 && bus.pc != 8'hFF; i++) step();
      chk("reach_ff", bus.pc, 8'hFF);
      step();
      chk("wrap", bus.pc, 8'h00);

      // Conditional taken, with a held request during the bubble.
      set_br(1, 2'd0, 1, 8'h40, 8'h00);
      step();
      chk("jcc_pc", bus.pc, 8'h40);
      chk("jcc_flush", bus.flush, 1'b1);
      chk("jcc_fv", bus.fetch_valid, 1'b0);
      set_br(1, 2'd1, 0, 8'h55, 8'h00);
      step();
      chk("held_pc", bus.pc, 8'h40);
      chk("held_flush", bus.flush, 1'b0);

      set_br(1, 2'd0, 0, 8'h40, 8'h00);
      step();
      chk("jcc_nt_pc", bus.pc, 8'h41);
      chk("jcc_nt_flush", bus.flush, 1'b0);

      // Call at 0x10, then return.
      set_br(1, 2'd1, 0, 8'h10, 8'h00);
      step();
      set_br(1, 2'd2, 0, 8'h80, 8'h11);
      step();
      chk("at_10", bus.pc, 8'h10);
      step();
      chk("call_pc", bus.pc, 8'h80);
      set_br(0, 2'd0, 0, 8'h00, 8'h00);
      step();
      set_br(1, 2'd3, 0, 8'h00, 8'h00);
      step();
      chk("ret_pc", bus.pc, 8'h11);
      chk("ret_flush", bus.flush, 1'b1);
      set_br(0, 2'd0, 0, 8'h00, 8'h00);
      step();

      // Overflow then drain in LIFO order, then underflow.
      for (int i = 0; i < 5; i++) begin
         set_br(1, 2'd2, 0, 8'h20 + 8'(i), 8'hA0 + 8'(i));
         step();
         set_br(0, 2'd0, 0, 8'h00, 8'h00);
         step();
      end
      chk("ovf_err", bus.ras_err, 1'b1);
      chk("ovf_pc", bus.pc, 8'h24);
      for (int i = 0; i < 4; i++) begin
         set_br(1, 2'd3, 0, 8'h00, 8'h00);
         step();
         chk("lifo_pc", bus.pc, 8'hA3 - 8'(i));
         set_br(0, 2'd0, 0, 8'h00, 8'h00);
         step();
      end
      set_br(1, 2'd3, 0, 8'h00, 8'h00);
      step();
      chk("unf_flush", bus.flush, 1'b0);
      chk("unf_fv", bus.fetch_valid, 1'b1);
      set_br(0, 2'd0, 0, 8'h00, 8'h00);
      step();

      // Reset landing mid-REDIRECT.
      set_br(1, 2'd2, 0, 8'h77, 8'h33);
      step();
      chk("pre_rst_flush", bus.flush, 1'b1);
      rst = 1'b0;
      set_br(0, 2'd0, 0, 8'h00, 8'h00);
      step();
      chk("rr_pc", bus.pc, 8'h00);
      chk("rr_flush", bus.flush, 1'b0);
      chk("rr_fv", bus.fetch_valid, 1'b0);
      chk("rr_err", bus.ras_err, 1'b0);
      rst = 1'b1;
      step();
      set_br(1, 2'd3, 0, 8'h00, 8'h00);
      step();
      chk("rr_ras_empty", bus.flush, 1'b0);
      chk("rr_ras_err", bus.ras_err, 1'b1);

      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 80) != 0);
         bus.fetch_ready = $urandom_range(0, 3) != 0;
         set_br($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
